// File: rtl/axis_fifo_pkg.sv
// Shared sizing defaults and helpers for the AXI-Stream FIFO buffer.
package axis_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 16;

  // Pointer width: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream handshake bundle with sink (s_axis) and source (m_axis) views.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport s_axis (input tvalid, input tdata, output tready);
  modport m_axis (output tvalid, output tdata, input tready);

endinterface

// File: rtl/axis_fifo_ctrl.sv
// FIFO bookkeeping: wrap-bit pointers, level, flags, and push/pop/flush handling.
module axis_fifo_ctrl
  import axis_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH         = DEF_DEPTH,
  parameter  int unsigned AFULL_THRESH  = DEF_DEPTH - 2,
  parameter  int unsigned AEMPTY_THRESH = 1,
  localparam int unsigned PTR_W         = ptr_width(DEPTH),
  localparam int unsigned IDX_W         = PTR_W - 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_s_tvalid,
  input  logic             i_m_tready,
  input  logic             i_flush,
  output logic             o_s_tready,
  output logic             o_m_tvalid,
  output logic             o_wr_en,
  output logic [IDX_W-1:0] o_wr_idx,
  output logic [IDX_W-1:0] o_rd_idx,
  output logic [PTR_W-1:0] o_level,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty
);

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t r_wr_ptr;
  ptr_t r_rd_ptr;
  logic r_ready;

  ptr_t w_level;
  logic w_full;
  logic w_empty;
  logic w_s_tready;
  logic w_m_tvalid;
  logic w_push;
  logic w_pop;

  // Everything below is derived from registered pointers (plus flush for tready).
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                      (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_s_tready = r_ready && !w_full && !i_flush;
  assign w_m_tvalid = !w_empty;
  assign w_push     = i_s_tvalid && w_s_tready;
  assign w_pop      = w_m_tvalid && i_m_tready;

  // r_ready holds tready low during reset and the cycle of release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign o_s_tready     = w_s_tready;
  assign o_m_tvalid     = w_m_tvalid;
  assign o_wr_en        = w_push;
  assign o_wr_idx       = r_wr_ptr[IDX_W-1:0];
  assign o_rd_idx       = r_rd_ptr[IDX_W-1:0];
  assign o_level        = w_level;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (w_level >= PTR_W'(AFULL_THRESH));
  assign o_almost_empty = (w_level <= PTR_W'(AEMPTY_THRESH));

  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst) !(w_push && w_full));
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst) !(w_pop && w_empty));
  a_level_range:  assert property (@(posedge i_clk) disable iff (i_rst) w_level <= PTR_W'(DEPTH));

endmodule

// File: rtl/axis_fifo_buf.sv
// First-word-fall-through AXI-Stream FIFO: storage array around axis_fifo_ctrl.
module axis_fifo_buf
  import axis_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int unsigned DEPTH         = DEF_DEPTH,
  parameter  int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter  int unsigned AEMPTY_THRESH = 1,
  localparam int unsigned PTR_W         = ptr_width(DEPTH),
  localparam int unsigned IDX_W         = PTR_W - 1
) (
  input  logic             aclk,
  input  logic             areset,
  axis_if.s_axis           s_axis,
  axis_if.m_axis           m_axis,
  input  logic             flush,
  output logic [PTR_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_s_tready;
  logic             w_m_tvalid;

  axis_fifo_ctrl #(
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_ctrl (
    .i_clk          (aclk),
    .i_rst          (areset),
    .i_s_tvalid     (s_axis.tvalid),
    .i_m_tready     (m_axis.tready),
    .i_flush        (flush),
    .o_s_tready     (w_s_tready),
    .o_m_tvalid     (w_m_tvalid),
    .o_wr_en        (w_wr_en),
    .o_wr_idx       (w_wr_idx),
    .o_rd_idx       (w_rd_idx),
    .o_level        (level),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty)
  );

  // Storage is intentionally not reset; only pointers define validity.
  always_ff @(posedge aclk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= s_axis.tdata;
  end

  assign s_axis.tready = w_s_tready;
  assign m_axis.tvalid = w_m_tvalid;
  assign m_axis.tdata  = r_mem[w_rd_idx];

endmodule

// File: tb/tb_axis_fifo_buf.sv
// Self-checking bench for axis_fifo_buf against a queue-based reference model.
module tb_axis_fifo_buf;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 1;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [LW-1:0] level;
  logic          full, empty, almost_full, almost_empty;

  axis_if #(.DATA_WIDTH(DW)) s_if ();
  axis_if #(.DATA_WIDTH(DW)) m_if ();

  axis_fifo_buf #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .aclk         (clk),
    .areset       (rst),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .flush        (flush),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored words plus "out of reset for one edge" flag.
  logic [DW-1:0] q[$];
  bit            mdl_ready = 1'b0;

  function automatic bit exp_tready();
    return mdl_ready && (q.size() < DEPTH) && !flush;
  endfunction

  function automatic bit exp_tvalid();
    return q.size() != 0;
  endfunction

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic tick();
    bit            do_push, do_pop;
    logic [DW-1:0] din;
    do_push = s_if.tvalid && exp_tready();
    do_pop  = exp_tvalid() && m_if.tready;
    din     = s_if.tdata;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mdl_ready = 1'b0;
    end else begin
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(din);
      end
      mdl_ready = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (level !== LW'(0)) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", almost_full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", almost_empty); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_if.tvalid); end
    rst = 1'b0;
    #1;
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL release_tready_early got %b exp 0", s_if.tready); end
    tick();
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b exp 1", s_if.tready); end
    checks++; if (empty !== 1'b1 || level !== LW'(0)) begin errors++; $display("FAIL idle_empty got empty=%b level=%0d exp 1/0", empty, level); end
  endtask

  task automatic test_fill_drain();
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'(32'hA0 + i);
      #1;
      checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL fill_tready[%0d] got %b exp 1", i, s_if.tready); end
      checks++; if (level !== LW'(i)) begin errors++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i); end
      checks++; if (almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, i >= 14); end
      tick();
    end
    s_if.tdata = DW'(32'hBAD);
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (level !== LW'(16)) begin errors++; $display("FAIL full_level got %0d exp 16", level); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL full_tready got %b exp 0", s_if.tready); end
    tick();
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL drain_tvalid[%0d] got %b exp 1", i, m_if.tvalid); end
      checks++; if (m_if.tdata !== DW'(32'hA0 + i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, m_if.tdata, 32'hA0 + i); end
      checks++; if (almost_empty !== (16 - i <= 1)) begin errors++; $display("FAIL drain_aempty[%0d] got %b", i, almost_empty); end
      tick();
    end
    m_if.tready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL drain_end got empty=%b tvalid=%b exp 1/0", empty, m_if.tvalid); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] sent[$];
    int            nrecv = 0;
    int            cyc   = 0;
    int            nsent = 0;
    while (nrecv < 40 && cyc < 400) begin
      s_if.tvalid = (cyc % 2 == 0) && (nsent < 40);
      s_if.tdata  = $urandom;
      m_if.tready = (cyc % 2 == 0);
      #1;
      checks++; if (level !== LW'(q.size()) || level > LW'(2)) begin errors++; $display("FAIL stream_level cyc %0d got %0d exp %0d", cyc, level, q.size()); end
      if (s_if.tvalid && s_if.tready) begin sent.push_back(s_if.tdata); nsent++; end
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (sent.size() == 0 || m_if.tdata !== sent[0]) begin
          errors++; $display("FAIL stream_data word %0d got %h", nrecv, m_if.tdata);
        end
        if (sent.size() != 0) void'(sent.pop_front());
        nrecv++;
      end
      tick();
      cyc++;
    end
    checks++; if (nrecv != 40) begin errors++; $display("FAIL stream_timeout got %0d words exp 40", nrecv); end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_if.tdata = DW'(32'hC0 + i);
      tick();
    end
    s_if.tdata  = DW'(32'h77);
    m_if.tready = 1'b1;
    #1;
    checks++; if (s_if.tready !== 1'b0 || level !== LW'(16)) begin errors++; $display("FAIL fpp_full got tready=%b level=%0d exp 0/16", s_if.tready, level); end
    tick();
    m_if.tready = 1'b0;
    #1;
    checks++; if (level !== LW'(15)) begin errors++; $display("FAIL fpp_pop_only got level %0d exp 15", level); end
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL fpp_tready got %b exp 1", s_if.tready); end
    tick();
    s_if.tvalid = 1'b0;
    #1;
    checks++; if (level !== LW'(16) || full !== 1'b1) begin errors++; $display("FAIL fpp_refill got level %0d full %b exp 16/1", level, full); end
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (m_if.tdata !== q[0]) begin errors++; $display("FAIL fpp_drain[%0d] got %h exp %h", i, m_if.tdata, q[0]); end
      if (i == 15) begin
        checks++; if (m_if.tdata !== DW'(32'h77)) begin errors++; $display("FAIL fpp_last got %h exp 77", m_if.tdata); end
      end
      tick();
    end
    m_if.tready = 1'b0;
  endtask

  task automatic test_flush();
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_if.tdata = $urandom;
      tick();
    end
    s_if.tdata = DW'(32'hDEAD);
    flush      = 1'b1;
    #1;
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL flush_tready got %b exp 0", s_if.tready); end
    checks++; if (level !== LW'(5)) begin errors++; $display("FAIL preflush_level got %0d exp 5", level); end
    tick();
    flush       = 1'b0;
    s_if.tvalid = 1'b0;
    #1;
    checks++; if (level !== LW'(0) || empty !== 1'b1 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL postflush got level %0d empty %b tvalid %b exp 0/1/0", level, empty, m_if.tvalid); end
    s_if.tvalid = 1'b1;
    s_if.tdata  = DW'(32'h1234);
    tick();
    s_if.tvalid = 1'b0;
    #1;
    checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== DW'(32'h1234)) begin errors++; $display("FAIL flush_next got tvalid %b data %h exp 1/1234", m_if.tvalid, m_if.tdata); end
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_dead_stored got empty %b exp 1", empty); end
  endtask

  task automatic test_reset_mid();
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_if.tdata = $urandom;
      tick();
    end
    #1;
    checks++; if (level !== LW'(7)) begin errors++; $display("FAIL mid_level got %0d exp 7", level); end
    rst = 1'b1;
    q.delete();
    mdl_ready = 1'b0;
    #1;
    checks++; if (level !== LW'(0) || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin errors++; $display("FAIL mid_reset got level %0d tvalid %b tready %b exp 0/0/0", level, m_if.tvalid, s_if.tready); end
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      s_if.tdata = DW'(32'h5000 + i);
      tick();
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_if.tdata !== DW'(32'h5000 + i)) begin errors++; $display("FAIL mid_fresh[%0d] got %h exp %h", i, m_if.tdata, 32'h5000 + i); end
      tick();
    end
    m_if.tready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_end_empty got %b exp 1", empty); end
  endtask

  task automatic test_random();
    int p_push;
    for (int c = 0; c < 600; c++) begin
      p_push      = (c < 300) ? 80 : 30;
      s_if.tvalid = ($urandom_range(99) < p_push);
      s_if.tdata  = $urandom;
      m_if.tready = ($urandom_range(99) < 50);
      flush       = ($urandom_range(99) < 2);
      #1;
      checks++;
      if (level !== LW'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
          almost_full !== (q.size() >= AF) || almost_empty !== (q.size() <= AE)) begin
        errors++;
        $display("FAIL rnd_flags cyc %0d got lvl %0d f%b e%b af%b ae%b exp lvl %0d", c, level, full, empty, almost_full, almost_empty, q.size());
      end
      checks++;
      if (s_if.tready !== exp_tready() || m_if.tvalid !== exp_tvalid()) begin
        errors++;
        $display("FAIL rnd_hs cyc %0d got tready %b tvalid %b exp %b %b", c, s_if.tready, m_if.tvalid, exp_tready(), exp_tvalid());
      end
      if (q.size() != 0) begin
        checks++;
        if (m_if.tdata !== q[0]) begin errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, m_if.tdata, q[0]); end
      end
      tick();
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    flush       = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_pop_push();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
